// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared encodings for the memory arbiter: FSM states and one-hot grant values.
package mem_arbiter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LDR  = 2'b10;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Requester and memory-side signals of the arbiter, bundled with arbiter (slave)
// and environment (master) views.
interface mem_arbiter_ctrl_if #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_ADDR = 12
);

  // Handshake: a requester raises Req with Write/Addr/WData stable and holds it
  // until it samples its one-cycle Ack; on that same edge it drops or re-arms Req.
  // Req still high in the IDLE cycle after Ack starts a new transaction.
  logic                      cpuReq;
  logic                      cpuWrite;
  logic [DATAWIDTH_ADDR-1:0] cpuAddr;
  logic [DATAWIDTH_BUS-1:0]  cpuWData;
  logic                      cpuAck;
  logic                      cpuStall;

  logic                      ldrReq;
  logic                      ldrWrite;
  logic [DATAWIDTH_ADDR-1:0] ldrAddr;
  logic [DATAWIDTH_BUS-1:0]  ldrWData;
  logic                      ldrAck;

  logic [DATAWIDTH_BUS-1:0]  rData;
  logic [1:0]                grant;

  logic                      memEnable;
  logic                      memWrite;
  logic [DATAWIDTH_ADDR-1:0] memAddr;
  logic [DATAWIDTH_BUS-1:0]  memWData;
  logic [DATAWIDTH_BUS-1:0]  memRData;

  modport slave (
    input  cpuReq, cpuWrite, cpuAddr, cpuWData,
    input  ldrReq, ldrWrite, ldrAddr, ldrWData,
    input  memRData,
    output cpuAck, cpuStall, ldrAck, rData, grant,
    output memEnable, memWrite, memAddr, memWData
  );

  modport master (
    output cpuReq, cpuWrite, cpuAddr, cpuWData,
    output ldrReq, ldrWrite, ldrAddr, ldrWData,
    output memRData,
    input  cpuAck, cpuStall, ldrAck, rData, grant,
    input  memEnable, memWrite, memAddr, memWData
  );

endinterface

// File: rtl/mem_arbiter_ctrl_priority.sv
// Grant select for the two requesters. With MEM_ARBITER_ROUND_ROBIN_EN defined, a
// pointer register alternates simultaneous grants; otherwise the CPU always wins.
module mem_arbiter_ctrl_priority
  import mem_arbiter_ctrl_pkg::*;
(
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       grantEn,
`endif
  input  logic       cpuReq,
  input  logic       ldrReq,
  output logic [1:0] grant
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = the loader was granted most recently, so the CPU wins the next tie.
  logic lastLdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastLdr <= 1'b1;
    end else if (grantEn && (grant != GNT_NONE)) begin
      lastLdr <= (grant == GNT_LDR);
    end
  end

  always_comb begin
    grant = GNT_NONE;
    if (cpuReq && ldrReq) begin
      grant = lastLdr ? GNT_CPU : GNT_LDR;
    end else if (cpuReq) begin
      grant = GNT_CPU;
    end else if (ldrReq) begin
      grant = GNT_LDR;
    end
  end
`else
  always_comb begin
    grant = GNT_NONE;
    if (cpuReq) begin
      grant = GNT_CPU;
    end else if (ldrReq) begin
      grant = GNT_LDR;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shares a single-port data memory between the CPU and the loader with a fixed-latency
// IDLE -> ACCESS -> ACK sequence. Optional macro: MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_ADDR = 12,
  parameter int WAIT_STATES    = 2,
  parameter int WAIT_CNT_WIDTH = 4
) (
  input  logic                MemArbiter_CLOCK_50,
  input  logic                MemArbiter_Reset_InHigh,
  mem_arbiter_ctrl_if.slave   bus,
  output state_t              dbgState
);

  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE  = WAIT_CNT_WIDTH'(1);

  state_t                    state;
  state_t                    nextState;
  logic [1:0]                selGrant;
  logic [1:0]                grantQ;
  logic                      writeQ;
  logic [DATAWIDTH_ADDR-1:0] addrQ;
  logic [DATAWIDTH_BUS-1:0]  wdataQ;
  logic [DATAWIDTH_BUS-1:0]  rdataQ;
  logic [WAIT_CNT_WIDTH-1:0] waitCnt;
  logic                      anyReq;
  logic                      startAccess;
  logic                      lastAccess;

  assign anyReq      = bus.cpuReq | bus.ldrReq;
  assign startAccess = (state == ST_IDLE) && anyReq;
  assign lastAccess  = (state == ST_ACCESS) && (waitCnt == '0);

  mem_arbiter_ctrl_priority u_priority (
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    .clk     (MemArbiter_CLOCK_50),
    .rst     (MemArbiter_Reset_InHigh),
    .grantEn (startAccess),
`endif
    .cpuReq  (bus.cpuReq),
    .ldrReq  (bus.ldrReq),
    .grant   (selGrant)
  );

  always_ff @(posedge MemArbiter_CLOCK_50) begin
    if (MemArbiter_Reset_InHigh) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (anyReq) nextState = ST_ACCESS;
      ST_ACCESS: if (waitCnt == '0) nextState = ST_ACK;
      ST_ACK:    nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  // Transaction latch, wait counter and read-data capture.
  always_ff @(posedge MemArbiter_CLOCK_50) begin
    if (MemArbiter_Reset_InHigh) begin
      grantQ  <= GNT_NONE;
      writeQ  <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      rdataQ  <= '0;
      waitCnt <= '0;
    end else begin
      if (startAccess) begin
        grantQ  <= selGrant;
        waitCnt <= CNT_LOAD;
        if (selGrant == GNT_LDR) begin
          writeQ <= bus.ldrWrite;
          addrQ  <= bus.ldrAddr;
          wdataQ <= bus.ldrWData;
        end else begin
          writeQ <= bus.cpuWrite;
          addrQ  <= bus.cpuAddr;
          wdataQ <= bus.cpuWData;
        end
      end else if (lastAccess) begin
        if (!writeQ) rdataQ <= bus.memRData;
      end else if (state == ST_ACCESS) begin
        waitCnt <= waitCnt - CNT_ONE;
      end else if (state == ST_ACK) begin
        grantQ <= GNT_NONE;
      end
    end
  end

  assign bus.memEnable = (state == ST_ACCESS);
  assign bus.memWrite  = (state == ST_ACCESS) && writeQ;
  assign bus.memAddr   = addrQ;
  assign bus.memWData  = wdataQ;
  assign bus.cpuAck    = (state == ST_ACK) && (grantQ == GNT_CPU);
  assign bus.ldrAck    = (state == ST_ACK) && (grantQ == GNT_LDR);
  assign bus.cpuStall  = bus.cpuReq & ~bus.cpuAck;
  assign bus.rData     = rdataQ;
  assign bus.grant     = grantQ;
  assign dbgState      = state;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: one DUT with 2 wait states, one with 0.
module tb_mem_arbiter_ctrl;
  import mem_arbiter_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg;
  state_t dbg0;
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter_ctrl_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(12)) bus ();
  mem_arbiter_ctrl_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(12)) bus0 ();

  mem_arbiter_ctrl #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(12), .WAIT_STATES(2), .WAIT_CNT_WIDTH(4)) u_dut (
    .MemArbiter_CLOCK_50     (clk),
    .MemArbiter_Reset_InHigh (rst),
    .bus                     (bus),
    .dbgState                (dbg)
  );

  mem_arbiter_ctrl #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(12), .WAIT_STATES(0), .WAIT_CNT_WIDTH(4)) u_dut0 (
    .MemArbiter_CLOCK_50     (clk),
    .MemArbiter_Reset_InHigh (rst),
    .bus                     (bus0),
    .dbgState                (dbg0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    if (dbg !== ST_IDLE) begin $display("FAIL reset_state got %0d exp %0d", dbg, ST_IDLE); miscompares++; end
    vectors++;
    if (bus.memEnable !== 1'b0 || bus.memWrite !== 1'b0) begin $display("FAIL reset_mem_ctrl got en=%b wr=%b exp 0 0", bus.memEnable, bus.memWrite); miscompares++; end
    vectors++;
    if (bus.rData !== 32'h0) begin $display("FAIL reset_rdata got %h exp 0", bus.rData); miscompares++; end
    vectors++;
    if (bus.grant !== 2'b00 || bus.cpuAck !== 1'b0 || bus.ldrAck !== 1'b0) begin $display("FAIL reset_grant_ack got g=%b ca=%b la=%b exp 00 0 0", bus.grant, bus.cpuAck, bus.ldrAck); miscompares++; end
    vectors++;
    if (bus.memAddr !== 12'h0 || bus.memWData !== 32'h0) begin $display("FAIL reset_mem_bus got a=%h d=%h exp 0 0", bus.memAddr, bus.memWData); miscompares++; end
    vectors++;
    rst = 1'b0;
    tick();
    if (dbg !== ST_IDLE || dbg0 !== ST_IDLE || bus.memEnable !== 1'b0) begin $display("FAIL reset_idle_hold got s=%0d s0=%0d en=%b exp 0 0 0", dbg, dbg0, bus.memEnable); miscompares++; end
    vectors++;
  endtask

  task automatic test_cpu_read();
    bus.memRData = 32'hDEADBEEF;
    bus.cpuWrite = 1'b0;
    bus.cpuAddr  = 12'h010;
    bus.cpuWData = 32'h0;
    bus.cpuReq   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.memEnable !== (k <= 3)) begin $display("FAIL cpu_read_en k=%0d got %b exp %b", k, bus.memEnable, (k <= 3)); miscompares++; end
      vectors++;
      if (bus.cpuAck !== (k == 4) || bus.ldrAck !== 1'b0) begin $display("FAIL cpu_read_ack k=%0d got ca=%b la=%b exp %b 0", k, bus.cpuAck, bus.ldrAck, (k == 4)); miscompares++; end
      vectors++;
      if (k <= 3) begin
        if (bus.memAddr !== 12'h010 || bus.memWrite !== 1'b0 || bus.grant !== GNT_CPU) begin $display("FAIL cpu_read_access k=%0d got a=%h wr=%b g=%b exp 010 0 01", k, bus.memAddr, bus.memWrite, bus.grant); miscompares++; end
        vectors++;
        if (bus.cpuStall !== 1'b1) begin $display("FAIL cpu_read_stall k=%0d got %b exp 1", k, bus.cpuStall); miscompares++; end
        vectors++;
      end
      if (k == 4) begin
        if (bus.rData !== 32'hDEADBEEF) begin $display("FAIL cpu_read_rdata got %h exp deadbeef", bus.rData); miscompares++; end
        vectors++;
        bus.cpuReq = 1'b0;
      end
    end
  endtask

  task automatic test_ldr_write();
    bus.memRData = 32'hA5A5A5A5;
    bus.ldrWrite = 1'b1;
    bus.ldrAddr  = 12'h020;
    bus.ldrWData = 32'h12345678;
    bus.ldrReq   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.memEnable !== (k <= 3) || bus.memWrite !== (k <= 3)) begin $display("FAIL ldr_write_en k=%0d got en=%b wr=%b exp %b", k, bus.memEnable, bus.memWrite, (k <= 3)); miscompares++; end
      vectors++;
      if (k <= 3) begin
        if (bus.memAddr !== 12'h020 || bus.memWData !== 32'h12345678) begin $display("FAIL ldr_write_bus k=%0d got a=%h d=%h exp 020 12345678", k, bus.memAddr, bus.memWData); miscompares++; end
        vectors++;
      end
      if (bus.ldrAck !== (k == 4) || bus.cpuAck !== 1'b0 || bus.cpuStall !== 1'b0) begin $display("FAIL ldr_write_ack k=%0d got la=%b ca=%b st=%b exp %b 0 0", k, bus.ldrAck, bus.cpuAck, bus.cpuStall, (k == 4)); miscompares++; end
      vectors++;
      if (bus.grant !== ((k <= 4) ? GNT_LDR : GNT_NONE)) begin $display("FAIL ldr_write_grant k=%0d got %b exp %b", k, bus.grant, ((k <= 4) ? GNT_LDR : GNT_NONE)); miscompares++; end
      vectors++;
      if (bus.rData !== 32'hDEADBEEF) begin $display("FAIL ldr_write_rdata k=%0d got %h exp deadbeef", k, bus.rData); miscompares++; end
      vectors++;
      if (k == 4) bus.ldrReq = 1'b0;
    end
  endtask

  task automatic test_both_requests();
    logic [1:0] expOwner [4];
    logic [1:0] owner;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    expOwner = '{GNT_CPU, GNT_LDR, GNT_CPU, GNT_LDR};
`else
    expOwner = '{GNT_CPU, GNT_CPU, GNT_CPU, GNT_CPU};
`endif
    bus.memRData = 32'hCAFEF00D;
    bus.cpuWrite = 1'b0;
    bus.cpuAddr  = 12'h100;
    bus.ldrWrite = 1'b0;
    bus.ldrAddr  = 12'h200;
    bus.cpuReq   = 1'b1;
    bus.ldrReq   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      owner = expOwner[(k - 1) / 5];
      if ((k % 5) == 4) begin
        if (bus.cpuAck !== (owner == GNT_CPU) || bus.ldrAck !== (owner == GNT_LDR)) begin $display("FAIL both_ack k=%0d got ca=%b la=%b exp owner %b", k, bus.cpuAck, bus.ldrAck, owner); miscompares++; end
        vectors++;
      end else begin
        if (bus.cpuAck !== 1'b0 || bus.ldrAck !== 1'b0) begin $display("FAIL both_noack k=%0d got ca=%b la=%b exp 0 0", k, bus.cpuAck, bus.ldrAck); miscompares++; end
        vectors++;
      end
      if ((k % 5) >= 1 && (k % 5) <= 3) begin
        if (bus.memAddr !== ((owner == GNT_CPU) ? 12'h100 : 12'h200) || bus.grant !== owner) begin $display("FAIL both_access k=%0d got a=%h g=%b exp owner %b", k, bus.memAddr, bus.grant, owner); miscompares++; end
        vectors++;
      end
      if (k == 19) begin
        bus.cpuReq = 1'b0;
        bus.ldrReq = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bus.memRData = 32'h11112222;
    bus.cpuWrite = 1'b0;
    bus.cpuAddr  = 12'h030;
    bus.cpuReq   = 1'b1;
    tick();
    tick();
    if (bus.memEnable !== 1'b1 || dbg !== ST_ACCESS) begin $display("FAIL rst_mid_pre got en=%b s=%0d exp 1 1", bus.memEnable, dbg); miscompares++; end
    vectors++;
    rst = 1'b1;
    bus.cpuReq = 1'b0;
    tick();
    if (dbg !== ST_IDLE || bus.memEnable !== 1'b0 || bus.memWrite !== 1'b0) begin $display("FAIL rst_mid_idle got s=%0d en=%b wr=%b exp 0 0 0", dbg, bus.memEnable, bus.memWrite); miscompares++; end
    vectors++;
    if (bus.rData !== 32'h0 || bus.grant !== 2'b00) begin $display("FAIL rst_mid_clear got r=%h g=%b exp 0 00", bus.rData, bus.grant); miscompares++; end
    vectors++;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.cpuAck !== 1'b0 || bus.memEnable !== 1'b0) begin $display("FAIL rst_mid_noack k=%0d got ca=%b en=%b exp 0 0", k, bus.cpuAck, bus.memEnable); miscompares++; end
      vectors++;
    end
  endtask

  task automatic test_back_to_back();
    bus0.memRData = 32'h0BADF00D;
    bus0.cpuWrite = 1'b0;
    bus0.cpuAddr  = 12'h050;
    bus0.cpuReq   = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (bus0.memEnable !== ((k % 3) == 1)) begin $display("FAIL b2b_en k=%0d got %b exp %b", k, bus0.memEnable, ((k % 3) == 1)); miscompares++; end
      vectors++;
      if (bus0.cpuAck !== ((k % 3) == 2)) begin $display("FAIL b2b_ack k=%0d got %b exp %b", k, bus0.cpuAck, ((k % 3) == 2)); miscompares++; end
      vectors++;
      if ((k % 3) == 2) begin
        if (bus0.rData !== 32'h0BADF00D) begin $display("FAIL b2b_rdata k=%0d got %h exp 0badf00d", k, bus0.rData); miscompares++; end
        vectors++;
      end
      if (k == 9) bus0.cpuReq = 1'b0;
    end
  endtask

  task automatic test_req_drop();
    bus.memRData = 32'h55AA55AA;
    bus.cpuWrite = 1'b0;
    bus.cpuAddr  = 12'h040;
    bus.cpuReq   = 1'b1;
    tick();
    if (bus.cpuStall !== 1'b1 || bus.memEnable !== 1'b1) begin $display("FAIL drop_first got st=%b en=%b exp 1 1", bus.cpuStall, bus.memEnable); miscompares++; end
    vectors++;
    bus.cpuReq = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (bus.cpuStall !== 1'b0) begin $display("FAIL drop_stall k=%0d got %b exp 0", k, bus.cpuStall); miscompares++; end
      vectors++;
      if (bus.cpuAck !== (k == 4) || bus.memEnable !== (k <= 3)) begin $display("FAIL drop_ack k=%0d got ca=%b en=%b exp %b %b", k, bus.cpuAck, bus.memEnable, (k == 4), (k <= 3)); miscompares++; end
      vectors++;
      if (k == 4) begin
        if (bus.rData !== 32'h55AA55AA) begin $display("FAIL drop_rdata got %h exp 55aa55aa", bus.rData); miscompares++; end
        vectors++;
      end
    end
  endtask

  initial begin
    bus.cpuReq = 1'b0;  bus.cpuWrite = 1'b0;  bus.cpuAddr = '0;  bus.cpuWData = '0;
    bus.ldrReq = 1'b0;  bus.ldrWrite = 1'b0;  bus.ldrAddr = '0;  bus.ldrWData = '0;
    bus.memRData = '0;
    bus0.cpuReq = 1'b0; bus0.cpuWrite = 1'b0; bus0.cpuAddr = '0; bus0.cpuWData = '0;
    bus0.ldrReq = 1'b0; bus0.ldrWrite = 1'b0; bus0.ldrAddr = '0; bus0.ldrWData = '0;
    bus0.memRData = '0;

    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_both_requests();
    test_reset_mid_access();
    test_back_to_back();
    test_req_drop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
